// File: rtl/ddr_req_sched.sv
// Schedules the shared DDR port among load, store and fetch requesters, one transaction at a time.
// Optional build macro DDR_TIMEOUT_EN adds a WAIT-state watchdog that drives the sticky err_timeout.
module ddr_req_sched #(
  parameter int unsigned IDX_W        = 19,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               opload_index_valid,
  input  logic [IDX_W-1:0]   opload_index,
  output logic               opload_index_ready,
  output logic [63:0]        opload_read_data,
  output logic               opload_operation_done,
  input  logic               opstore_index_valid,
  input  logic [IDX_W-1:0]   opstore_index,
  input  logic [63:0]        opstore_write_mask,
  input  logic [63:0]        opstore_write_data,
  output logic               opstore_index_ready,
  output logic               opstore_operation_done,
  input  logic               pc_index_valid,
  input  logic [IDX_W-1:0]   pc_index,
  output logic               pc_index_ready,
  output logic [511:0]       pc_read_inst,
  output logic               pc_operation_done,
  output logic               ddr_chip_enable,
  output logic [IDX_W-1:0]   ddr_index,
  output logic               ddr_write_enable,
  output logic               ddr_burst_mode,
  output logic [63:0]        ddr_opstore_write_mask,
  output logic [63:0]        ddr_opstore_write_data,
  input  logic [63:0]        ddr_opload_read_data,
  input  logic [511:0]       ddr_pc_read_inst,
  input  logic               ddr_operation_done,
  input  logic               ddr_ready,
  output logic               err_timeout
);

  localparam int unsigned AgeW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AgeW-1:0] AgeMax = AgeW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  typedef enum logic [1:0] {OwnNone, OwnLoad, OwnStore, OwnPc} own_e;

  state_e          state_q;
  own_e            owner_q;
  own_e            grant;
  logic [AgeW-1:0] store_age_q;
  logic [AgeW-1:0] pc_age_q;
  logic            accept;

  function automatic logic [AgeW-1:0] age_next(input logic [AgeW-1:0] age, input logic valid,
                                               input logic won);
    if (won) return '0;
    if (valid && (age != AgeMax)) return age + 1'b1;
    return age;
  endfunction

  // Promoted channels override the base order; pc outranks store when both are promoted.
  always_comb begin
    grant = OwnNone;
    if (pc_index_valid && (pc_age_q == AgeMax))             grant = OwnPc;
    else if (opstore_index_valid && (store_age_q == AgeMax)) grant = OwnStore;
    else if (opload_index_valid)                             grant = OwnLoad;
    else if (opstore_index_valid)                            grant = OwnStore;
    else if (pc_index_valid)                                 grant = OwnPc;
  end

  assign accept              = (state_q == StIdle) && ddr_ready && (grant != OwnNone);
  assign opload_index_ready  = accept && (grant == OwnLoad);
  assign opstore_index_ready = accept && (grant == OwnStore);
  assign pc_index_ready      = accept && (grant == OwnPc);

`ifdef DDR_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] wait_cnt_q;
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign err_timeout        = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q                <= StIdle;
      owner_q                <= OwnNone;
      store_age_q            <= '0;
      pc_age_q               <= '0;
      ddr_chip_enable        <= 1'b0;
      ddr_index              <= '0;
      ddr_write_enable       <= 1'b0;
      ddr_burst_mode         <= 1'b0;
      ddr_opstore_write_mask <= '0;
      ddr_opstore_write_data <= '0;
      opload_read_data       <= '0;
      pc_read_inst           <= '0;
      opload_operation_done  <= 1'b0;
      opstore_operation_done <= 1'b0;
      pc_operation_done      <= 1'b0;
`ifdef DDR_TIMEOUT_EN
      wait_cnt_q             <= '0;
      err_timeout            <= 1'b0;
`endif
    end else begin
      ddr_chip_enable        <= 1'b0;
      opload_operation_done  <= 1'b0;
      opstore_operation_done <= 1'b0;
      pc_operation_done      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            owner_q          <= grant;
            ddr_index        <= (grant == OwnLoad)  ? opload_index  :
                                (grant == OwnStore) ? opstore_index : pc_index;
            ddr_write_enable <= (grant == OwnStore);
            ddr_burst_mode   <= (grant == OwnPc);
            ddr_opstore_write_mask <= (grant == OwnStore) ? opstore_write_mask : '0;
            ddr_opstore_write_data <= (grant == OwnStore) ? opstore_write_data : '0;
            ddr_chip_enable  <= 1'b1;
            store_age_q      <= age_next(store_age_q, opstore_index_valid, grant == OwnStore);
            pc_age_q         <= age_next(pc_age_q, pc_index_valid, grant == OwnPc);
            state_q          <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StWait;
`ifdef DDR_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        StWait: begin
          if (ddr_operation_done) begin
            if (owner_q == OwnLoad) opload_read_data <= ddr_opload_read_data;
            if (owner_q == OwnPc)   pc_read_inst     <= ddr_pc_read_inst;
            opload_operation_done  <= (owner_q == OwnLoad);
            opstore_operation_done <= (owner_q == OwnStore);
            pc_operation_done      <= (owner_q == OwnPc);
            state_q                <= StIdle;
          end
`ifdef DDR_TIMEOUT_EN
          // Abandon the transaction: complete it with zeroed read data and flag the error.
          else if (wait_cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
            if (owner_q == OwnLoad) opload_read_data <= '0;
            if (owner_q == OwnPc)   pc_read_inst     <= '0;
            opload_operation_done  <= (owner_q == OwnLoad);
            opstore_operation_done <= (owner_q == OwnStore);
            pc_operation_done      <= (owner_q == OwnPc);
            err_timeout            <= 1'b1;
            state_q                <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
